// File: rtl/cnn_job_ctrl_pkg.sv
// Shared definitions for the CNN job controller: FSM encodings, status codes
// and the default image geometry also used by cnn_top.
package cnn_job_ctrl_pkg;

    localparam int IMG_SIZE_DEF = 64;
    localparam int PIX_W_DEF    = 32;
    localparam int OUT_W_DEF    = 32;
    localparam int TIMEOUT_DEF  = 4096;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_START  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESULT = 2'd3
    } state_t;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_SHORT   = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_LONG    = 2'd3;

endpackage

// File: rtl/cnn_img_buffer.sv
// Image register file: one indexed write port, whole image visible on a
// flattened read bus (pixel i at [i*PIX_W +: PIX_W]).
module cnn_img_buffer #(
    parameter int IMG_SIZE = 64,
    parameter int PIX_W    = 32,
    parameter int IDX_W    = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [IDX_W-1:0]          wr_idx,
    input  logic [PIX_W-1:0]          wr_data,
    output logic [IMG_SIZE*PIX_W-1:0] img
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            img <= '0;
        end else if (wr_en) begin
            img[wr_idx*PIX_W +: PIX_W] <= wr_data;
        end
    end

endmodule

// File: rtl/cnn_job_ctrl.sv
// Single-image job controller for cnn_top: buffers one frame, pulses the
// core enable, waits for done (with timeout) and returns a status-tagged result.
module cnn_job_ctrl
    import cnn_job_ctrl_pkg::*;
#(
    parameter int IMG_SIZE    = IMG_SIZE_DEF,
    parameter int PIX_W       = PIX_W_DEF,
    parameter int OUT_W       = OUT_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s_pix_valid,
    output logic                      s_pix_ready,
    input  logic [PIX_W-1:0]          s_pix_data,
    input  logic                      s_pix_last,
    output logic [IMG_SIZE*PIX_W-1:0] core_img,
    output logic                      core_enable,
    input  logic [OUT_W-1:0]          core_value,
    input  logic                      core_done,
    output logic                      m_res_valid,
    input  logic                      m_res_ready,
    output logic [OUT_W-1:0]          m_res_data,
    output logic [1:0]                m_res_err,
    output logic                      busy
);

    localparam int IDX_W = $clog2(IMG_SIZE);
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IMG_SIZE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC - 1);

    state_t           state;
    logic [IDX_W-1:0] wr_idx;
    logic [CNT_W-1:0] to_cnt;
    logic [1:0]       err_lat;
    logic             pix_fire;

    // Both channels transfer on a cycle where valid and ready are high together;
    // s_pix_ready and m_res_valid are registered copies of the state decode.
    assign pix_fire = s_pix_valid & s_pix_ready;
    assign busy     = (state != ST_LOAD) || (wr_idx != '0);

    cnn_img_buffer #(
        .IMG_SIZE (IMG_SIZE),
        .PIX_W    (PIX_W),
        .IDX_W    (IDX_W)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (pix_fire),
        .wr_idx  (wr_idx),
        .wr_data (s_pix_data),
        .img     (core_img)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_LOAD;
            wr_idx      <= '0;
            to_cnt      <= '0;
            err_lat     <= ERR_OK;
            s_pix_ready <= 1'b0;
            core_enable <= 1'b0;
            m_res_valid <= 1'b0;
            m_res_data  <= '0;
            m_res_err   <= ERR_OK;
        end else begin
            core_enable <= 1'b0;
            case (state)
                ST_LOAD: begin
                    s_pix_ready <= 1'b1;
                    if (pix_fire) begin
                        wr_idx <= wr_idx + IDX_W'(1);
                        if (wr_idx == LAST_IDX) begin
                            // A full frame runs even without last; the status records it.
                            state       <= ST_START;
                            core_enable <= 1'b1;
                            s_pix_ready <= 1'b0;
                            if (!s_pix_last) err_lat <= ERR_LONG;
                        end else if (s_pix_last) begin
                            state       <= ST_RESULT;
                            s_pix_ready <= 1'b0;
                            m_res_valid <= 1'b1;
                            m_res_data  <= '0;
                            m_res_err   <= ERR_SHORT;
                        end
                    end
                end
                ST_START: begin
                    to_cnt <= '0;
                    state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    to_cnt <= to_cnt + CNT_W'(1);
                    if (core_done) begin
                        state       <= ST_RESULT;
                        m_res_valid <= 1'b1;
                        m_res_data  <= core_value;
                        m_res_err   <= err_lat;
                    end else if (to_cnt == CNT_MAX) begin
                        state       <= ST_RESULT;
                        m_res_valid <= 1'b1;
                        m_res_data  <= '0;
                        m_res_err   <= ERR_TIMEOUT;
                    end
                end
                ST_RESULT: begin
                    if (m_res_ready) begin
                        state       <= ST_LOAD;
                        m_res_valid <= 1'b0;
                        s_pix_ready <= 1'b1;
                        wr_idx      <= '0;
                        err_lat     <= ERR_OK;
                    end
                end
                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_job_ctrl.sv
// Directed bench for cnn_job_ctrl with a behavioural core and a result scoreboard.
module tb_cnn_job_ctrl;
    import cnn_job_ctrl_pkg::*;

    localparam int IMG_SIZE    = 64;
    localparam int PIX_W       = 32;
    localparam int OUT_W       = 32;
    localparam int TIMEOUT_CYC = 16;

    logic                      clk;
    logic                      rst;
    logic                      s_pix_valid;
    logic                      s_pix_ready;
    logic [PIX_W-1:0]          s_pix_data;
    logic                      s_pix_last;
    logic [IMG_SIZE*PIX_W-1:0] core_img;
    logic                      core_enable;
    logic [OUT_W-1:0]          core_value;
    logic                      core_done;
    logic                      m_res_valid;
    logic                      m_res_ready;
    logic [OUT_W-1:0]          m_res_data;
    logic [1:0]                m_res_err;
    logic                      busy;

    cnn_job_ctrl #(
        .IMG_SIZE    (IMG_SIZE),
        .PIX_W       (PIX_W),
        .OUT_W       (OUT_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_pix_valid (s_pix_valid),
        .s_pix_ready (s_pix_ready),
        .s_pix_data  (s_pix_data),
        .s_pix_last  (s_pix_last),
        .core_img    (core_img),
        .core_enable (core_enable),
        .core_value  (core_value),
        .core_done   (core_done),
        .m_res_valid (m_res_valid),
        .m_res_ready (m_res_ready),
        .m_res_data  (m_res_data),
        .m_res_err   (m_res_err),
        .busy        (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int en_cnt   = 0;
    logic [OUT_W+1:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (core_enable) en_cnt <= en_cnt + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // scoreboard: every result handshake must match the next queued expectation
    always @(negedge clk) begin
        if (rst && m_res_valid && m_res_ready) begin
            if (exp_q.size() == 0) begin
                check("result_expected", 64'(exp_q.size()), 64'd1);
            end else begin
                logic [OUT_W+1:0] e;
                e = exp_q.pop_front();
                check("result", 64'({m_res_err, m_res_data}), 64'(e));
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int n, input logic [31:0] base, input int step,
                              input int last_at);
        int sent;
        int guard;
        sent  = 0;
        guard = 0;
        while (sent < n && guard < 500) begin
            s_pix_valid = 1'b1;
            s_pix_data  = base + 32'(step * sent);
            s_pix_last  = (sent == last_at);
            if (s_pix_ready) sent++;
            tick();
            guard++;
        end
        s_pix_valid = 1'b0;
        s_pix_last  = 1'b0;
        s_pix_data  = '0;
        check("frame_beats_accepted", 64'(sent), 64'(n));
    endtask

    function automatic int img_bad(input logic [31:0] base, input int step);
        int bad;
        logic [PIX_W-1:0] px;
        bad = 0;
        for (int i = 0; i < IMG_SIZE; i++) begin
            px = core_img[i*PIX_W +: PIX_W];
            if (px !== base + 32'(step * i)) bad++;
        end
        return bad;
    endfunction

    // core model: called in the enable cycle, raises done `delay` cycles later
    task automatic run_core(input int delay, input logic [31:0] val);
        for (int i = 0; i < delay; i++) begin
            tick();
            if (i == 0) check("enable_one_cycle", 64'(core_enable), 64'd0);
        end
        check("valid_before_done", 64'(m_res_valid), 64'd0);
        core_done  = 1'b1;
        core_value = val;
        tick();
        core_done  = 1'b0;
        core_value = '0;
    endtask

    task automatic handshake();
        m_res_ready = 1'b1;
        tick();
        m_res_ready = 1'b0;
        check("pix_ready_after_hs", 64'(s_pix_ready), 64'd1);
        check("valid_after_hs", 64'(m_res_valid), 64'd0);
    endtask

    task automatic check_result(input string tag, input logic [1:0] err, input logic [31:0] data);
        check({tag, "_valid"}, 64'(m_res_valid), 64'd1);
        check({tag, "_err"}, 64'(m_res_err), 64'(err));
        check({tag, "_data"}, 64'(m_res_data), 64'(data));
    endtask

    int e0;
    int bad_v, bad_d, bad_r;

    initial begin
        rst = 1'b0; s_pix_valid = 1'b0; s_pix_data = '0; s_pix_last = 1'b0;
        core_value = '0; core_done = 1'b0; m_res_ready = 1'b0;
        repeat (3) tick();
        check("rst_pix_ready", 64'(s_pix_ready), 64'd0);
        check("rst_enable", 64'(core_enable), 64'd0);
        check("rst_res_valid", 64'(m_res_valid), 64'd0);
        check("rst_res_data", 64'(m_res_data), 64'd0);
        check("rst_res_err", 64'(m_res_err), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_img_zero", 64'(img_bad(0, 0)), 64'd0);
        rst = 1'b1;
        tick();
        check("post_rst_pix_ready", 64'(s_pix_ready), 64'd1);
        check("post_rst_busy", 64'(busy), 64'd0);

        // nominal frame: 64 ones, core answers 64 after 10 cycles
        e0 = en_cnt;
        exp_q.push_back({ERR_OK, 32'd64});
        send_frame(64, 32'd1, 0, 63);
        check("nom_enable", 64'(core_enable), 64'd1);
        check("nom_pix_ready_low", 64'(s_pix_ready), 64'd0);
        check("nom_img", 64'(img_bad(32'd1, 0)), 64'd0);
        run_core(10, 32'd64);
        check_result("nom", ERR_OK, 32'd64);
        check("nom_enable_count", 64'(en_cnt - e0), 64'd1);
        handshake();

        // short frame: last on beat 9, core never started
        e0 = en_cnt;
        exp_q.push_back({ERR_SHORT, 32'd0});
        send_frame(10, 32'd7, 1, 9);
        check_result("short", ERR_SHORT, 32'd0);
        check("short_busy", 64'(busy), 64'd1);
        repeat (3) tick();
        check("short_no_enable", 64'(en_cnt - e0), 64'd0);
        handshake();
        check("short_idle_busy", 64'(busy), 64'd0);

        // frame after short runs normally with a ramp image
        exp_q.push_back({ERR_OK, 32'h1234});
        send_frame(64, 32'd5, 3, 63);
        check("ramp_img", 64'(img_bad(32'd5, 3)), 64'd0);
        run_core(4, 32'h1234);
        check_result("ramp", ERR_OK, 32'h1234);
        handshake();

        // long frame: last never set
        exp_q.push_back({ERR_LONG, 32'hABCD});
        send_frame(64, 32'h100, 1, -1);
        check("long_enable", 64'(core_enable), 64'd1);
        run_core(6, 32'hABCD);
        check_result("long", ERR_LONG, 32'hABCD);
        handshake();

        // timeout: no done, result 17 cycles after enable
        exp_q.push_back({ERR_TIMEOUT, 32'd0});
        send_frame(64, 32'd2, 0, 63);
        check("to_enable", 64'(core_enable), 64'd1);
        repeat (16) tick();
        check("to_valid_early", 64'(m_res_valid), 64'd0);
        tick();
        check_result("to", ERR_TIMEOUT, 32'd0);
        handshake();

        // done on the final count wins over timeout
        exp_q.push_back({ERR_OK, 32'h55AA});
        send_frame(64, 32'd3, 0, 63);
        run_core(16, 32'h55AA);
        check_result("to_edge", ERR_OK, 32'h55AA);
        handshake();

        // back-pressure with a spurious done
        exp_q.push_back({ERR_OK, 32'h77});
        send_frame(64, 32'd4, 0, 63);
        run_core(10, 32'h77);
        bad_v = 0; bad_d = 0; bad_r = 0;
        s_pix_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin core_done = 1'b1; core_value = 32'hDEAD; end
            if (i == 6) begin core_done = 1'b0; core_value = '0; end
            if (m_res_valid !== 1'b1) bad_v++;
            if (m_res_data !== 32'h77 || m_res_err !== ERR_OK) bad_d++;
            if (s_pix_ready !== 1'b0) bad_r++;
            tick();
        end
        s_pix_valid = 1'b0;
        check("bp_valid_held", 64'(bad_v), 64'd0);
        check("bp_data_stable", 64'(bad_d), 64'd0);
        check("bp_pix_ready_low", 64'(bad_r), 64'd0);
        handshake();

        // reset in WAIT aborts the job
        e0 = en_cnt;
        send_frame(64, 32'd9, 0, 63);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("mid_rst_pix_ready", 64'(s_pix_ready), 64'd0);
        check("mid_rst_valid", 64'(m_res_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_img", 64'(img_bad(0, 0)), 64'd0);
        rst = 1'b1;
        tick();
        check("mid_rst_ready_back", 64'(s_pix_ready), 64'd1);
        core_done = 1'b1; core_value = 32'hBAD;
        tick();
        core_done = 1'b0; core_value = '0;
        repeat (3) tick();
        check("mid_rst_no_result", 64'(m_res_valid), 64'd0);
        check("mid_rst_enable_count", 64'(en_cnt - e0), 64'd1);

        exp_q.push_back({ERR_OK, 32'h99});
        send_frame(64, 32'd20, 2, 63);
        check("post_rst_img", 64'(img_bad(32'd20, 2)), 64'd0);
        run_core(5, 32'h99);
        check_result("post_rst", ERR_OK, 32'h99);
        handshake();

        repeat (2) tick();
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        check("enable_total", 64'(en_cnt), 64'd8);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
